// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        VEC_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_t;

    localparam int CTRL_CNT_W_DEFAULT = 4;
    localparam int PERF_CNT_W         = 32;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with zero flag, shared by the VEC_WAIT and FLUSH timers.
// Latency: load/decrement visible one cycle later; zero flag is combinational from the count.
// Backpressure: none; decrement is ignored once the count reaches zero.
module ctrl_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multicycle vector ops, taken branches.
// Latency: enables/flushes/bubble are combinational; state, counter and vec_busy update on clk.
// Backpressure: freezes PC/IF/ID/ID/EX and injects EX/MEM bubbles; PIPE_PERF_CNT_EN adds stall/flush counters.
module pipeline_ctrl_unit
    import proc_ctrl_pkg::*;
#(
    parameter int VEC_LATENCY  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = CTRL_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_use_stall,
    input  logic       vec_start,
    input  logic       branch_taken,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_bubble,
    output logic       vec_busy,
    output logic [1:0] ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_cycles
`endif
);

    // Counter preloads are N-2: the entry cycle is spent in RUN and the exit cycle sees zero.
    localparam logic [CNT_W-1:0] VEC_LOAD   = CNT_W'(VEC_LATENCY - 2);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = (FLUSH_CYCLES >= 2) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
    localparam bit               FLUSH_MULTI = (FLUSH_CYCLES > 1);

    ctrl_state_t      state, state_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             busy_set;
    logic             busy_clr;

    ctrl_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_busy <= 1'b0;
        end else if (busy_set) begin
            vec_busy <= 1'b1;
        end else if (busy_clr) begin
            vec_busy <= 1'b0;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;
        busy_set      = 1'b0;
        busy_clr      = 1'b0;

        case (state)
            RUN: begin
                if (load_use_stall) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                end else if (vec_start) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_load      = 1'b1;
                    cnt_load_val  = VEC_LOAD;
                    busy_set      = 1'b1;
                    state_nxt     = VEC_WAIT;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (FLUSH_MULTI) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = FLUSH_LOAD;
                        state_nxt    = FLUSH;
                    end
                end
            end

            VEC_WAIT: begin
                // Hazard inputs are ignored here; vec_start is still high in the release cycle.
                if (!cnt_zero) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_dec       = 1'b1;
                end else begin
                    busy_clr  = 1'b1;
                    state_nxt = RUN;
                end
            end

            FLUSH: begin
                if_id_flush = 1'b1;
                if (cnt_zero) begin
                    state_nxt = RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase

        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b0;
        end
    end

    assign ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_en) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (if_id_flush) begin
                flush_cycles <= sat_inc(flush_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit with VEC_LATENCY=4, FLUSH_CYCLES=2.
// Inputs change on the falling edge; outputs are sampled 2ns later, mid-cycle.
module tb_pipeline_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use_stall = 1'b0;
    logic vec_start = 1'b0;
    logic branch_taken = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_bubble, vec_busy;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Packed view: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble}
    logic [7:0] outs;
    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_bubble};

    localparam logic [7:0] O_RST   = 8'h06;
    localparam logic [7:0] O_IDLE  = 8'hF8;
    localparam logic [7:0] O_STALL = 8'h19;
    localparam logic [7:0] O_BR    = 8'hFE;
    localparam logic [7:0] O_FLUSH = 8'hFC;

    always #5 clk = ~clk;

    pipeline_ctrl_unit #(.VEC_LATENCY(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_use_stall (load_use_stall),
        .vec_start      (vec_start),
        .branch_taken   (branch_taken),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .vec_busy       (vec_busy),
        .ctrl_state     (ctrl_state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles)
`endif
    );

    task automatic drive(input logic lus, input logic vs, input logic br);
        @(negedge clk);
        load_use_stall = lus;
        vec_start      = vs;
        branch_taken   = br;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            total_cnt++;
            if (outs !== O_RST) $display("FAIL reset_outs cyc%0d: got %h want %h", i, outs, O_RST);
            else pass_cnt++;
        end
        total_cnt++;
        if (ctrl_state !== 2'd0 || vec_busy !== 1'b0)
            $display("FAIL reset_state: got state=%0d busy=%b want 0/0", ctrl_state, vec_busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #2;
        total_cnt++;
        if (outs !== O_IDLE || ctrl_state !== 2'd0)
            $display("FAIL post_reset: got outs=%h state=%0d want %h/0", outs, ctrl_state, O_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (outs !== O_STALL || ctrl_state !== 2'd0)
            $display("FAIL load_use_stall: got outs=%h state=%0d want %h/0", outs, ctrl_state, O_STALL);
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (outs !== O_IDLE || ctrl_state !== 2'd0)
            $display("FAIL load_use_after: got outs=%h state=%0d want %h/0", outs, ctrl_state, O_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_vector();
        logic [7:0] exp_o [5];
        logic [1:0] exp_s [5];
        logic       exp_b [5];
        exp_o = '{O_STALL, O_STALL, O_STALL, O_IDLE, O_IDLE};
        exp_s = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, (i < 4), 1'b0);
            total_cnt++;
            if (outs !== exp_o[i] || ctrl_state !== exp_s[i] || vec_busy !== exp_b[i])
                $display("FAIL vector cyc%0d: got outs=%h state=%0d busy=%b want %h/%0d/%b",
                         i + 1, outs, ctrl_state, vec_busy, exp_o[i], exp_s[i], exp_b[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_branch();
        logic [7:0] exp_o [3];
        logic [1:0] exp_s [3];
        exp_o = '{O_BR, O_FLUSH, O_IDLE};
        exp_s = '{2'd0, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, (i == 0));
            total_cnt++;
            if (outs !== exp_o[i] || ctrl_state !== exp_s[i])
                $display("FAIL branch cyc%0d: got outs=%h state=%0d want %h/%0d",
                         i, outs, ctrl_state, exp_o[i], exp_s[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp_o [6];
        logic [1:0] exp_s [6];
        logic       lus   [6];
        exp_o = '{O_STALL, O_STALL, O_STALL, O_STALL, O_IDLE, O_IDLE};
        exp_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        // Load stall first, then again in the release cycle where it must be ignored.
        lus   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(lus[i], (i < 5), (i < 5));
            total_cnt++;
            if (outs !== exp_o[i] || ctrl_state !== exp_s[i])
                $display("FAIL priority cyc%0d: got outs=%h state=%0d want %h/%0d",
                         i, outs, ctrl_state, exp_o[i], exp_s[i]);
            else pass_cnt++;
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_s [9];
        exp_s = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, (i < 8), 1'b0);
            total_cnt++;
            if (ctrl_state !== exp_s[i] || ex_mem_bubble !== (i != 3 && i != 7 && i != 8))
                $display("FAIL back_to_back cyc%0d: got state=%0d bubble=%b want %0d/%b",
                         i, ctrl_state, ex_mem_bubble, exp_s[i], (i != 3 && i != 7 && i != 8));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_vec();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        total_cnt++;
        if (ctrl_state !== 2'd1 || vec_busy !== 1'b1)
            $display("FAIL vec_mid: got state=%0d busy=%b want 1/1", ctrl_state, vec_busy);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ctrl_state !== 2'd0 || vec_busy !== 1'b0 || outs !== O_RST)
            $display("FAIL async_reset: got state=%0d busy=%b outs=%h want 0/0/%h",
                     ctrl_state, vec_busy, outs, O_RST);
        else pass_cnt++;
`ifdef PIPE_PERF_CNT_EN
        total_cnt++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0)
            $display("FAIL perf_clear: got stall=%0d flush=%0d want 0/0", stall_cycles, flush_cycles);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst = 1'b0;
        vec_start = 1'b0;
        #2;
        total_cnt++;
        if (ctrl_state !== 2'd0 || outs !== O_IDLE)
            $display("FAIL after_async_reset: got state=%0d outs=%h want 0/%h", ctrl_state, outs, O_IDLE);
        else pass_cnt++;
`ifdef PIPE_PERF_CNT_EN
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (stall_cycles !== 32'd1 || flush_cycles !== 32'd2)
            $display("FAIL perf_count: got stall=%0d flush=%0d want 1/2", stall_cycles, flush_cycles);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_vector();
        test_branch();
        test_priority();
        test_back_to_back();
        test_reset_in_vec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
